// File: rtl/montgomery_domain_conv.sv
// Bidirectional Montgomery-domain converter: y = a*B*2^-NBITS mod m with B=1 (FROM) or B=r2 (TO),
// using a bit-serial radix-2 reduction over NBITS cycles and one final conditional subtract.
module montgomery_domain_conv #(
  parameter int NBITS = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_p,
  input  logic             mode,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] m,
  input  logic [NBITS-1:0] r2,
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             done_irq_p
);

  localparam int CNTW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FINAL
  } state_t;

  state_t           r_state;
  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_m;
  logic [NBITS-1:0] r_b;
  logic [NBITS+1:0] r_t;
  logic [CNTW-1:0]  r_cnt;
  logic [NBITS-1:0] r_y;
  logic             r_busy;
  logic             r_done;

  logic [NBITS+1:0] w_t1;
  logic [NBITS+1:0] w_t2;
  logic             w_ge;
  logic [NBITS-1:0] w_sub;

  // r_a is shifted right each iteration, so bit 0 is always the current multiplier bit.
  assign w_t1  = r_t + (r_a[0] ? {2'b00, r_b} : '0);
  assign w_t2  = w_t1 + (w_t1[0] ? {2'b00, r_m} : '0);
  assign w_ge  = (r_t >= {2'b00, r_m});
  // T < 2m, so T - m fits in NBITS bits whenever the subtraction is selected.
  assign w_sub = r_t[NBITS-1:0] - r_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_b     <= '0;
      r_t     <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable_p) begin
            r_a     <= a;
            r_m     <= m;
            r_b     <= mode ? r2 : NBITS'(1);
            r_t     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_t   <= w_t2 >> 1;
          r_a   <= r_a >> 1;
          r_cnt <= r_cnt + CNTW'(1);
          if (r_cnt == CNTW'(NBITS - 1)) begin
            r_state <= S_FINAL;
          end
        end
        S_FINAL: begin
          r_y     <= w_ge ? w_sub : r_t[NBITS-1:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign y          = r_y;
  assign busy       = r_busy;
  assign done_irq_p = r_done;

endmodule

// File: tb/tb_montgomery_domain_conv.sv
// Scoreboard bench for montgomery_domain_conv: an 8-bit instance for directed/corner cases and a
// 2048-bit instance for random full-width operands, both checked against a doubling/halving model.
module tb_montgomery_domain_conv;

  localparam int NB  = 8;
  localparam int BIG = 2048;

  typedef logic [BIG+1:0] wide_t;
  typedef struct {
    logic [BIG-1:0] y;
    int             acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tot;
  int   n_bad;

  logic          en8, mode8, busy8, done8;
  logic [NB-1:0] a8, m8, r28, y8;

  logic           enb, modeb, busyb, doneb;
  logic [BIG-1:0] ab, mb, r2b, yb;

  exp_t q8[$];
  exp_t qb[$];

  logic          prev8;
  logic          prevb;
  logic [NB-1:0] y_hold8;

  montgomery_domain_conv #(.NBITS(NB)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable_p(en8), .mode(mode8),
    .a(a8), .m(m8), .r2(r28), .y(y8), .busy(busy8), .done_irq_p(done8)
  );

  montgomery_domain_conv #(.NBITS(BIG)) dutb (
    .clk(clk), .rst_n(rst_n), .enable_p(enb), .mode(modeb),
    .a(ab), .m(mb), .r2(r2b), .y(yb), .busy(busyb), .done_irq_p(doneb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [BIG-1:0] got, input logic [BIG-1:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=..%h exp=..%h (low 64 bits) t=%0t", tag, got[63:0], exp[63:0], $time);
    end
  endtask

  // Reference: TO by NB modular doublings, FROM by NB modular halvings.
  function automatic wide_t ref_conv(input wide_t a, input wide_t m, input bit to, input int nb);
    wide_t x = a;
    for (int i = 0; i < nb; i++) begin
      if (to) begin
        x = x << 1;
        if (x >= m) x = x - m;
      end else begin
        if (x[0]) x = x + m;
        x = x >> 1;
      end
    end
    return x;
  endfunction

  function automatic wide_t ref_pow2(input int e, input wide_t m);
    wide_t x = 1;
    for (int i = 0; i < e; i++) begin
      x = x << 1;
      if (x >= m) x = x - m;
    end
    return x;
  endfunction

  function automatic logic [BIG-1:0] rnd_big();
    logic [BIG-1:0] v;
    for (int i = 0; i < BIG / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // 8-bit monitor: result, latency, pulse width, busy, and y stability between completions.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n) begin
      if (done8) begin
        chk("done_width8", {{(BIG-1){1'b0}}, prev8}, '0);
        chk("busy_at_done8", {{(BIG-1){1'b0}}, busy8}, '0);
        if (q8.size() == 0) begin
          chk("spurious_done8", {{(BIG-1){1'b0}}, done8}, '0);
        end else begin
          e = q8.pop_front();
          chk("y8", BIG'(y8), e.y);
          chk("latency8", BIG'(cyc - e.acc), BIG'(NB + 1));
        end
        y_hold8 <= y8;
      end else begin
        chk("y_hold8", BIG'(y8), BIG'(y_hold8));
        if (q8.size() > 0) chk("busy8", {{(BIG-1){1'b0}}, busy8}, BIG'(1));
      end
    end else begin
      y_hold8 <= '0;
    end
    prev8 <= done8;
  end

  always @(negedge clk) begin : monb
    exp_t e;
    if (rst_n && doneb) begin
      chk("done_widthb", {{(BIG-1){1'b0}}, prevb}, '0);
      if (qb.size() == 0) begin
        chk("spurious_doneb", {{(BIG-1){1'b0}}, doneb}, '0);
      end else begin
        e = qb.pop_front();
        chk("yb", yb, e.y);
        chk("latencyb", BIG'(cyc - e.acc), BIG'(BIG + 1));
      end
    end
    prevb <= doneb;
  end

  task automatic op8(input bit md, input logic [NB-1:0] av, input logic [NB-1:0] mv,
                     input logic [NB-1:0] rv, input logic [NB-1:0] ev);
    @(negedge clk);
    en8 = 1'b1; mode8 = md; a8 = av; m8 = mv; r28 = rv;
    @(posedge clk);
    #1;
    q8.push_back('{y: BIG'(ev), acc: cyc});
    en8 = 1'b0;
    a8 = NB'($urandom); m8 = NB'($urandom); r28 = NB'($urandom); mode8 = 1'($urandom);
    $display("op8 mode=%0d a=%0d m=%0d r2=%0d exp=%0d", md, av, mv, rv, ev);
  endtask

  task automatic wait8();
    for (int k = 0; k < NB + 20; k++) begin
      @(negedge clk);
      #2;
      if (q8.size() == 0 && !busy8) break;
    end
    chk("drain8", BIG'(q8.size()), '0);
  endtask

  task automatic opb(input bit md);
    logic [BIG-1:0] mv, av, rv;
    wide_t ev;
    mv = rnd_big();
    mv[0] = 1'b1;
    mv[BIG-1] = 1'b1;
    av = rnd_big();
    av[BIG-1] = 1'b0;
    rv = BIG'(ref_pow2(2 * BIG, {2'b00, mv}));
    ev = ref_conv({2'b00, av}, {2'b00, mv}, md, BIG);
    @(negedge clk);
    enb = 1'b1; modeb = md; ab = av; mb = mv; r2b = rv;
    @(posedge clk);
    #1;
    qb.push_back('{y: ev[BIG-1:0], acc: cyc});
    enb = 1'b0;
    ab = rnd_big(); mb = rnd_big();
    $display("opb mode=%0d a=..%h m=..%h exp=..%h", md, av[31:0], mv[31:0], ev[31:0]);
    for (int k = 0; k < BIG + 20; k++) begin
      @(negedge clk);
      #2;
      if (qb.size() == 0 && !busyb) break;
    end
    chk("drainb", BIG'(qb.size()), '0);
  endtask

  initial begin
    int acc;
    logic [NB-1:0] mv, av, rv;
    wide_t ev;
    n_tot = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0;
    en8 = 1'b0; mode8 = 1'b0; a8 = '0; m8 = '0; r28 = '0;
    enb = 1'b0; modeb = 1'b0; ab = '0; mb = '0; r2b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y8", BIG'(y8), '0);
    chk("rst_busy8", {{(BIG-1){1'b0}}, busy8}, '0);
    chk("rst_done8", {{(BIG-1){1'b0}}, done8}, '0);
    chk("rst_yb", yb, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, m=13, R mod m=9, r2=3.
    op8(1'b0, 8'd9,  8'd13, 8'd3, 8'd1);  wait8();
    op8(1'b1, 8'd1,  8'd13, 8'd3, 8'd9);  wait8();
    op8(1'b1, 8'd12, 8'd13, 8'd3, 8'd4);  wait8();
    op8(1'b0, 8'd4,  8'd13, 8'd3, 8'd12); wait8();
    op8(1'b0, 8'd0,  8'd13, 8'd3, 8'd0);  wait8();
    op8(1'b1, 8'd0,  8'd13, 8'd3, 8'd0);  wait8();
    op8(1'b0, 8'd12, 8'd13, 8'd3, 8'd10); wait8();

    // Second start mid-operation is ignored; then a start held across the done edge is
    // ignored on that edge and accepted on the next one.
    op8(1'b0, 8'd9, 8'd13, 8'd3, 8'd1);
    acc = cyc;
    repeat (2) @(negedge clk);
    en8 = 1'b1; mode8 = 1'b1; a8 = 8'd5; m8 = 8'd13; r28 = 8'd3;
    @(negedge clk);
    en8 = 1'b0;
    while (cyc < acc + NB) @(negedge clk);
    en8 = 1'b1; mode8 = 1'b1; a8 = 8'd12; m8 = 8'd13; r28 = 8'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    q8.push_back('{y: BIG'(8'd4), acc: cyc});
    en8 = 1'b0;
    $display("op8 back-to-back mode=1 a=12 m=13 r2=3 exp=4");
    wait8();

    // Reset during iteration 4: outputs return to reset values and no completion follows.
    op8(1'b1, 8'd7, 8'd13, 8'd3, 8'd11);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q8.delete();
    #1;
    chk("abort_y8", BIG'(y8), '0);
    chk("abort_busy8", {{(BIG-1){1'b0}}, busy8}, '0);
    chk("abort_done8", {{(BIG-1){1'b0}}, done8}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (NB + 4) @(negedge clk);
    $display("abort: reset at iteration 4, no completion expected");
    op8(1'b1, 8'd7, 8'd13, 8'd3, 8'd11); wait8();

    // Random odd moduli against the reference model.
    for (int i = 0; i < 12; i++) begin
      mv = NB'($urandom_range(3, 255)) | 8'd1;
      av = NB'($urandom_range(0, int'(mv) - 1));
      rv = NB'(ref_pow2(2 * NB, wide_t'(mv)));
      ev = ref_conv(wide_t'(av), wide_t'(mv), i[0], NB);
      op8(i[0], av, mv, rv, ev[NB-1:0]);
      wait8();
    end

    // Full-width operands in both directions.
    opb(1'b1);
    opb(1'b0);
    opb(1'b1);
    opb(1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
